// File: rtl/io_uart_tx.sv
// io_uart_tx: IO-mapped 8N1 serial transmitter.
// CPU writes to BASE queue bytes in a small circular FIFO. A sequencer shifts
// each byte out LSB first on TXD. Status at BASE+1 reports {ovf, full, busy}.
module io_uart_tx #(
  parameter logic [7:0] BASE       = 8'hF8,
  parameter int         CLK_DIV    = 434,
  parameter int         DEPTH_LOG2 = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] addr,
  input  logic       WE,
  input  logic       RE,
  input  logic [7:0] Din,
  output logic [7:0] Dout,
  output logic       TXD,
  output logic       busy
);

  localparam int               PTR_W     = DEPTH_LOG2;
  localparam int               CNT_W     = DEPTH_LOG2 + 1;
  localparam int               DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [7:0]       STAT_ADDR = BASE + 8'd1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mem_q [DEPTH];

  logic push_req_s;
  logic push_acc_s;
  logic drop_s;
  logic stat_rd_s;
  logic pop_s;
  logic full_s;
  logic nonempty_s;
  logic baud_end_s;

  // Decode bus strobes and derive FIFO occupancy flags from the current count.
  always_comb begin
    push_req_s = WE && (addr == BASE);
    stat_rd_s  = RE && (addr == STAT_ADDR);
    full_s     = (count_q == DEPTH_CNT);
    nonempty_s = (count_q != CNT_ZERO);
    push_acc_s = push_req_s && !full_s;
    drop_s     = push_req_s && full_s;
    baud_end_s = (baud_q == BAUD_LAST);
  end

  // Transmit sequencer: next state, baud counter, shift register and pops.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        if (nonempty_s) begin
          pop_s     = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = 3'd0;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          baud_d  = 16'd0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_end_s) begin
          baud_d    = 16'd0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_end_s) begin
          baud_d = 16'd0;
          // A queued byte starts immediately so frames run with no idle gap.
          if (nonempty_s) begin
            pop_s     = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = 3'd0;
            state_d   = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        baud_d  = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, taken from the next state so TXD is a pure flop.
  always_comb begin
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      ST_STOP:  txd_d = 1'b1;
      ST_IDLE:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO pointer/count bookkeeping and the sticky overflow flag.
  always_comb begin
    if (push_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_acc_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A drop wins over a same-cycle status read so the event is never lost.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (stat_rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Register all control state; reset truncates any frame and idles the line.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= CNT_ZERO;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage: written only on accepted pushes; contents need no reset.
  always_ff @(posedge Clock) begin
    if (push_acc_s && !Reset) begin
      mem_q[wr_ptr_q] <= Din;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Outputs: busy and the status read are decoded from registered state.
  always_comb begin
    TXD  = txd_q;
    busy = (state_q != ST_IDLE) || nonempty_s;
    if (stat_rd_s) begin
      Dout = {5'b00000, ovf_q, full_s, busy};
    end else begin
      Dout = 8'h00;
    end
  end

endmodule
